// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control slice.
//   state_t  : hazard sequencer states (RUN / WAIT / ERR)
//   REG_W    : register index width
//   REG_ZERO : index of the hard-wired zero register
package mips_pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear and saturation at MAX.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear (wins over inc)
//   inc        : increment request, ignored once saturated
//   count      : current value
//   sat        : count has reached MAX
module sat_counter #(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = (count == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central sequencer for the 5-stage MIPS pipeline.
// Resolves load-use stalls, taken-branch flushes and data-memory wait states
// (with timeout), and keeps a saturating stall-cycle counter.
//   Inputs : clk, rst_n (async, active-low), ID_Rs/ID_Rt/ID_UsesRt,
//            EX_MemRead/EX_RegDest, MEM_Branch/MEM_zero,
//            MEM_MemRead/MEM_MemWrite, dmem_ready
//   Outputs: PC_Write, *_Write enables, *_Flush, PCSrc (all combinational),
//            stall_count, mem_err (registered)
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_RegDest,
  input  logic             MEM_Branch,
  input  logic             MEM_zero,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IFtoID_Write,
  output logic             IDtoEX_Write,
  output logic             EXtoMEM_Write,
  output logic             MEMtoWB_Write,
  output logic             IFtoID_Flush,
  output logic             IDtoEX_Flush,
  output logic             EXtoMEM_Flush,
  output logic             PCSrc,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_err
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t          state;
  logic            mem_acc;
  logic            freeze;
  logic            taken;
  logic            lu;
  logic            wait_done;
  logic            stall_sat;
  logic [TW-1:0]   wait_cnt;

  always_comb begin
    mem_acc = MEM_MemRead | MEM_MemWrite;
    freeze  = 1'b1;
    case (state)
      RUN:     freeze = mem_acc & ~dmem_ready;
      WAIT:    freeze = ~dmem_ready;
      default: freeze = 1'b1;
    endcase
    taken = MEM_Branch & MEM_zero & ~freeze;
    lu    = EX_MemRead & (EX_RegDest != REG_ZERO) &
            ((EX_RegDest == ID_Rs) | (ID_UsesRt & (EX_RegDest == ID_Rt))) &
            ~freeze & ~taken;
  end

  always_comb begin
    PC_Write      = 1'b0;
    IFtoID_Write  = 1'b0;
    IDtoEX_Write  = 1'b0;
    EXtoMEM_Write = 1'b0;
    MEMtoWB_Write = 1'b0;
    IFtoID_Flush  = 1'b0;
    IDtoEX_Flush  = 1'b0;
    EXtoMEM_Flush = 1'b0;
    PCSrc         = 1'b0;
    if (!rst_n || freeze) begin
      // hold everything
    end else if (taken) begin
      PC_Write      = 1'b1;
      IFtoID_Write  = 1'b1;
      IDtoEX_Write  = 1'b1;
      EXtoMEM_Write = 1'b1;
      MEMtoWB_Write = 1'b1;
      IFtoID_Flush  = 1'b1;
      IDtoEX_Flush  = 1'b1;
      EXtoMEM_Flush = 1'b1;
      PCSrc         = 1'b1;
    end else if (lu) begin
      IDtoEX_Write  = 1'b1;
      EXtoMEM_Write = 1'b1;
      MEMtoWB_Write = 1'b1;
      IDtoEX_Flush  = 1'b1;
    end else begin
      PC_Write      = 1'b1;
      IFtoID_Write  = 1'b1;
      IDtoEX_Write  = 1'b1;
      EXtoMEM_Write = 1'b1;
      MEMtoWB_Write = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mem_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_acc && !dmem_ready) state <= WAIT;
        end
        WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (wait_done) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end
        end
        default: state <= ERR;
      endcase
    end
  end

  // Held clear for all of RUN, so it is zero on the first WAIT cycle;
  // saturation at MEM_TIMEOUT-1 doubles as the timeout flag.
  sat_counter #(
    .W   (TW),
    .MAX (TW'(MEM_TIMEOUT - 1))
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == RUN),
    .inc   (state == WAIT),
    .count (wait_cnt),
    .sat   (wait_done)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_stall_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   ((freeze | lu) & ~stall_sat),
    .count (stall_count),
    .sat   (stall_sat)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  import mips_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_Rs, ID_Rt, EX_RegDest;
  logic       ID_UsesRt, EX_MemRead, MEM_Branch, MEM_zero;
  logic       MEM_MemRead, MEM_MemWrite, dmem_ready;
  logic       PC_Write, IFtoID_Write, IDtoEX_Write, EXtoMEM_Write, MEMtoWB_Write;
  logic       IFtoID_Flush, IDtoEX_Flush, EXtoMEM_Flush, PCSrc;
  logic [3:0] stall_count;
  logic       mem_err;
  logic [8:0] ctl;

  int n_chk  = 0;
  int n_fail = 0;

  // {PC_Write, IFtoID_Write, IDtoEX_Write, EXtoMEM_Write, MEMtoWB_Write,
  //  IFtoID_Flush, IDtoEX_Flush, EXtoMEM_Flush, PCSrc}
  localparam logic [8:0] C_RUN  = 9'h1F0;
  localparam logic [8:0] C_LU   = 9'h074;
  localparam logic [8:0] C_BR   = 9'h1FF;
  localparam logic [8:0] C_HOLD = 9'h000;

  pipeline_hazard_ctrl #(
    .CNT_W       (4),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ID_Rs         (ID_Rs),
    .ID_Rt         (ID_Rt),
    .ID_UsesRt     (ID_UsesRt),
    .EX_MemRead    (EX_MemRead),
    .EX_RegDest    (EX_RegDest),
    .MEM_Branch    (MEM_Branch),
    .MEM_zero      (MEM_zero),
    .MEM_MemRead   (MEM_MemRead),
    .MEM_MemWrite  (MEM_MemWrite),
    .dmem_ready    (dmem_ready),
    .PC_Write      (PC_Write),
    .IFtoID_Write  (IFtoID_Write),
    .IDtoEX_Write  (IDtoEX_Write),
    .EXtoMEM_Write (EXtoMEM_Write),
    .MEMtoWB_Write (MEMtoWB_Write),
    .IFtoID_Flush  (IFtoID_Flush),
    .IDtoEX_Flush  (IDtoEX_Flush),
    .EXtoMEM_Flush (EXtoMEM_Flush),
    .PCSrc         (PCSrc),
    .stall_count   (stall_count),
    .mem_err       (mem_err)
  );

  assign ctl = {PC_Write, IFtoID_Write, IDtoEX_Write, EXtoMEM_Write, MEMtoWB_Write,
                IFtoID_Flush, IDtoEX_Flush, EXtoMEM_Flush, PCSrc};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UsesRt = 1'b1;
    EX_MemRead = 1'b0; EX_RegDest = 5'd9;
    MEM_Branch = 1'b0; MEM_zero = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; dmem_ready = 1'b1;
  endtask

  // check control outputs for the current cycle, then cross one rising edge
  task automatic cyc(input string tag, input logic [8:0] exp);
    #1 chk(tag, ctl, exp);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // reset: outputs forced low even with a load-use condition present
    EX_MemRead = 1'b1; EX_RegDest = 5'd8; ID_Rs = 5'd8;
    cyc("rst_ctl", C_HOLD);
    chk("rst_stall", stall_count, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_state", dut.state, RUN);
    rst_n = 1'b1;
    idle();

    cyc("normal", C_RUN);
    chk("normal_stall", stall_count, 0);

    // load-use on Rs
    EX_MemRead = 1'b1; EX_RegDest = 5'd8; ID_Rs = 5'd8;
    cyc("lu_rs", C_LU);
    chk("lu_rs_stall", stall_count, 1);

    // destination is $zero: no hazard
    EX_RegDest = 5'd0; ID_Rs = 5'd0;
    cyc("lu_zero", C_RUN);
    // Rt match but Rt not read
    EX_RegDest = 5'd8; ID_Rs = 5'd3; ID_Rt = 5'd8; ID_UsesRt = 1'b0;
    cyc("lu_rt_unused", C_RUN);
    chk("no_lu_stall", stall_count, 1);
    ID_UsesRt = 1'b1;
    cyc("lu_rt", C_LU);
    chk("lu_rt_stall", stall_count, 2);

    // branch beats load-use
    MEM_Branch = 1'b1; MEM_zero = 1'b1;
    cyc("br_over_lu", C_BR);
    chk("br_stall", stall_count, 2);
    idle();
    MEM_Branch = 1'b1;
    cyc("br_not_taken", C_RUN);

    // access completing immediately: no stall
    idle();
    MEM_MemRead = 1'b1;
    cyc("mem_ready", C_RUN);
    chk("mem_ready_state", dut.state, RUN);

    // three wait cycles with a pending taken branch
    MEM_Branch = 1'b1; MEM_zero = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mem_wait", C_HOLD);
    chk("mem_wait_state", dut.state, WAIT);
    dmem_ready = 1'b1;
    cyc("wait_release_br", C_BR);
    chk("wait_stall", stall_count, 5);
    chk("wait_back_run", dut.state, RUN);
    idle();
    cyc("after_wait", C_RUN);

    // timeout: 5 frozen cycles then ERR
    MEM_MemWrite = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("to_wait", C_HOLD);
    chk("to_err_pre", mem_err, 0);
    cyc("to_wait5", C_HOLD);
    chk("to_err", mem_err, 1);
    chk("to_state", dut.state, ERR);
    chk("to_stall", stall_count, 10);
    // ERR ignores ready and keeps freezing; stall counter saturates
    idle();
    for (int i = 0; i < 6; i++) cyc("err_hold", C_HOLD);
    chk("stall_sat", stall_count, 15);
    chk("err_sticky", mem_err, 1);

    // asynchronous reset out of ERR
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stall", stall_count, 0);
    chk("arst_err", mem_err, 0);
    chk("arst_state", dut.state, RUN);
    chk("arst_ctl", ctl, C_HOLD);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post_rst", C_RUN);
    chk("post_rst_stall", stall_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
